// File: rtl/phase_scheduler.sv
// Round-robin share of one iterative phasecalc core between two I/Q channels.
// Latency 4 + core compute cycles from capture to out_valid; inputs held off while a channel's slot is full.
module phase_scheduler #(
    parameter int INSIZE  = 13,
    parameter int OUTSIZE = 19,
    parameter int TIMEOUT = 64,
    parameter int TOSIZE  = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in0_valid,
    output logic               in0_ready,
    input  logic [INSIZE-1:0]  in0_x,
    input  logic [INSIZE-1:0]  in0_y,
    input  logic               in1_valid,
    output logic               in1_ready,
    input  logic [INSIZE-1:0]  in1_x,
    input  logic [INSIZE-1:0]  in1_y,
    output logic               core_start,
    input  logic               core_busy,
    output logic [INSIZE-1:0]  core_x,
    output logic [INSIZE-1:0]  core_y,
    input  logic [OUTSIZE-1:0] core_angle,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUTSIZE-1:0] out_angle,
    output logic               out_ch,
    output logic               err_timeout
);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_ARM, S_RUN, S_EMIT} state_t;

    state_t              state_q, state_d;
    logic                held0_q, held0_d, held1_q, held1_d;
    logic [INSIZE-1:0]   x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [INSIZE-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic                last_q, last_d, cur_q, cur_d;
    logic [TOSIZE-1:0]   tocnt_q, tocnt_d;
    logic                ovld_q, ovld_d, och_q, och_d, err_q, err_d;
    logic [OUTSIZE-1:0]  oang_q, oang_d;
    logic                serve;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            held0_q <= 1'b0;
            held1_q <= 1'b0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            last_q  <= 1'b1;
            cur_q   <= 1'b0;
            tocnt_q <= '0;
            ovld_q  <= 1'b0;
            och_q   <= 1'b0;
            oang_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            held0_q <= held0_d;
            held1_q <= held1_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            tocnt_q <= tocnt_d;
            ovld_q  <= ovld_d;
            och_q   <= och_d;
            oang_q  <= oang_d;
            err_q   <= err_d;
        end
    end

    // Tie goes to the channel not served last; a lone pending channel always wins.
    assign serve = (held0_q && held1_q) ? ~last_q : held1_q;

    always_comb begin
        state_d = state_q;
        held0_d = held0_q;
        held1_d = held1_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        last_d  = last_q;
        cur_d   = cur_q;
        tocnt_d = tocnt_q;
        ovld_d  = ovld_q;
        och_d   = och_q;
        oang_d  = oang_q;
        err_d   = err_q;

        if (in0_valid && !held0_q) begin
            held0_d = 1'b1;
            x0_d    = in0_x;
            y0_d    = in0_y;
        end
        if (in1_valid && !held1_q) begin
            held1_d = 1'b1;
            x1_d    = in1_x;
            y1_d    = in1_y;
        end

        case (state_q)
            S_IDLE: begin
                if (held0_q || held1_q) begin
                    cur_d   = serve;
                    last_d  = serve;
                    cx_d    = serve ? x1_q : x0_q;
                    cy_d    = serve ? y1_q : y0_q;
                    if (serve) held1_d = 1'b0;
                    else       held0_d = 1'b0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_ARM;
            S_ARM: begin
                tocnt_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!core_busy) begin
                    oang_d  = core_angle;
                    och_d   = cur_q;
                    ovld_d  = 1'b1;
                    state_d = S_EMIT;
                end else if (tocnt_q == TOSIZE'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tocnt_d = tocnt_q + 1'b1;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in0_ready   = ~held0_q;
    assign in1_ready   = ~held1_q;
    assign core_start  = (state_q == S_LAUNCH);
    assign core_x      = cx_q;
    assign core_y      = cy_q;
    assign out_valid   = ovld_q;
    assign out_angle   = oang_q;
    assign out_ch      = och_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: behavioural phasecalc core, per-channel scoreboard queues
// plus an expected grant-order queue, compared as results are handed out.
module tb_phase_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        in0_valid, in1_valid, in0_ready, in1_ready;
    logic [12:0] in0_x, in0_y, in1_x, in1_y;
    logic        core_start, core_busy;
    logic [12:0] core_x, core_y;
    logic [18:0] core_angle;
    logic        out_valid, out_ready, out_ch, err_timeout;
    logic [18:0] out_angle;

    int nvec = 0;
    int nmis = 0;
    int nres = 0;
    int nstart = 0;
    int last_angle = 0;
    int core_lat = 3;
    int core_cnt = 0;
    logic hang = 1'b0;

    int exp0_q[$];
    int exp1_q[$];
    int ord_q[$];

    phase_scheduler dut (
        .clock(clock), .reset(reset),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_x(in0_x), .in0_y(in0_y),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_x(in1_x), .in1_y(in1_y),
        .core_start(core_start), .core_busy(core_busy),
        .core_x(core_x), .core_y(core_y), .core_angle(core_angle),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_angle(out_angle), .out_ch(out_ch), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    function automatic int ang(input int x, input int y);
        real d;
        d = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979 * 1024.0;
        return (d >= 0.0) ? $rtoi(d + 0.5) : -$rtoi(-d + 0.5);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural core: busy rises the cycle after start, angle stable until next start.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            core_busy  <= 1'b0;
            core_angle <= '0;
            core_cnt   <= 0;
        end else if (core_start) begin
            core_busy  <= 1'b1;
            core_cnt   <= core_lat;
            core_angle <= 19'(ang($signed(core_x), $signed(core_y)));
        end else if (core_busy && !hang) begin
            if (core_cnt <= 1) core_busy <= 1'b0;
            else               core_cnt  <= core_cnt - 1;
        end
    end

    always @(negedge clock) if (core_start) nstart++;

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            nres++;
            last_angle = int'($signed(out_angle));
            if (ord_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                int ch;
                ch = ord_q.pop_front();
                check("out_ch", int'(out_ch), ch);
                if (ch == 0 && exp0_q.size() > 0)
                    check("out_angle_ch0", last_angle, exp0_q.pop_front());
                else if (ch == 1 && exp1_q.size() > 0)
                    check("out_angle_ch1", last_angle, exp1_q.pop_front());
                else
                    check("sb_empty", 1, 0);
            end
        end
    end

    task automatic send(input int ch, input int x, input int y);
        int t;
        t = 0;
        @(negedge clock);
        if (ch == 0) begin in0_valid = 1'b1; in0_x = 13'(x); in0_y = 13'(y); end
        else         begin in1_valid = 1'b1; in1_x = 13'(x); in1_y = 13'(y); end
        while (((ch == 0) ? !in0_ready : !in1_ready) && t < 500) begin
            @(negedge clock);
            t++;
        end
        if (t >= 500) begin
            check("send_stall", 0, 1);
        end else begin
            @(posedge clock);
            if (ch == 0) exp0_q.push_back(ang(x, y));
            else         exp1_q.push_back(ang(x, y));
            #1;
        end
        if (ch == 0) in0_valid = 1'b0;
        else         in1_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        int t;
        t = 0;
        while (nres < n && t < 1000) begin
            @(negedge clock);
            t++;
        end
        if (nres < n) check("wait_res", nres, n);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        exp0_q.delete(); exp1_q.delete(); ord_q.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t, base, s;
        reset = 1'b1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        in0_x = '0; in0_y = '0; in1_x = '0; in1_y = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_in0_ready", int'(in0_ready), 1);
        check("rst_in1_ready", int'(in1_ready), 1);
        check("rst_core_start", int'(core_start), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_angle", int'(out_angle), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_err", int'(err_timeout), 0);
        check("rst_core_xy", int'({core_x, core_y}), 0);
        reset = 1'b0;

        // Minimum latency with a core that drops busy before RUN
        core_lat = 1;
        ord_q.push_back(0);
        send(0, 100, 0);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        check("min_latency", t, 4);
        wait_res(1);
        check("t1_angle_tol", int'(last_angle >= -16 && last_angle <= 16), 1);

        core_lat = 5;
        ord_q.push_back(1);
        send(1, 0, 100);
        wait_res(2);
        check("t2_angle90_tol", int'(last_angle >= 92160 - 16 && last_angle <= 92160 + 16), 1);
        ord_q.push_back(1);
        send(1, -100, 1);
        wait_res(3);
        check("t2_angle179_tol", int'(last_angle >= 183733 - 16 && last_angle <= 183733 + 16), 1);

        // Simultaneous arrival after reset, then continuous traffic on both channels
        do_reset();
        base = nres;
        core_lat = 2;
        for (int i = 0; i < 8; i++) ord_q.push_back(i % 2);
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, 200 + i * 10, i * 37 - 50);
            end
            begin
                for (int j = 0; j < 4; j++) send(1, -150 + j * 20, 90 - j * 45);
            end
        join
        wait_res(base + 8);
        check("t3_order_drained", ord_q.size(), 0);

        // Backpressure in EMIT
        @(posedge clock); #1 out_ready = 1'b0;
        base = nres;
        ord_q.push_back(0);
        send(0, 50, 50);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("t4_out_valid_seen", int'(out_valid), 1);
        ord_q.push_back(1);
        send(1, -30, -40);
        s = nstart;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("t4_hold_valid", int'(out_valid), 1);
            check("t4_hold_angle", int'($signed(out_angle)), ang(50, 50));
            check("t4_hold_ch", int'(out_ch), 0);
        end
        check("t4_no_start", nstart - s, 0);
        @(posedge clock); #1 out_ready = 1'b1;
        wait_res(base + 2);

        // Core stuck busy -> timeout, sample dropped, arbitration continues
        hang = 1'b1;
        base = nres;
        check("t5_err_before", int'(err_timeout), 0);
        send(0, 10, 10);
        t = 0;
        while (!core_start && t < 50) begin
            @(negedge clock);
            t++;
        end
        t = 0;
        while (!err_timeout && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("t5_timeout_cycles", t, 66);
        check("t5_no_result", nres - base, 0);
        void'(exp0_q.pop_front());
        hang = 1'b0;
        s = nstart;
        ord_q.push_back(1);
        send(1, 5, -5);
        wait_res(base + 1);
        check("t5_relaunch", nstart - s, 1);
        check("t5_err_sticky", int'(err_timeout), 1);

        // Reset during RUN with both holding registers full
        core_lat = 30;
        send(0, 1, 2);
        send(0, 3, 4);
        send(1, 5, 6);
        check("t6_held0", int'(in0_ready), 0);
        check("t6_held1", int'(in1_ready), 0);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("t6_in0_ready", int'(in0_ready), 1);
        check("t6_in1_ready", int'(in1_ready), 1);
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_out_angle", int'(out_angle), 0);
        check("t6_out_ch", int'(out_ch), 0);
        check("t6_core_start", int'(core_start), 0);
        check("t6_core_xy", int'({core_x, core_y}), 0);
        check("t6_err", int'(err_timeout), 0);
        exp0_q.delete(); exp1_q.delete(); ord_q.delete();
        @(negedge clock);
        reset = 1'b0;
        base = nres;
        repeat (20) @(negedge clock);
        check("t6_no_output", nres - base, 0);
        check("t6_ready_after", int'({in0_ready, in1_ready}), 3);
        core_lat = 2;
        ord_q.push_back(0);
        send(0, 100, 100);
        wait_res(base + 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
